reg_operand_fetch: RTL and testbench

- Issue-side client of the MIPS register file. Accepts decoded instructions over a valid/ready handshake and drives the file's read addresses (sreg/treg). Captures operands into an output register and forwards them to execute.
- Also owns the file's write port (write/wreg/wdata), driven from the writeback bus. Provides same-cycle bypass and a per-register pending-write scoreboard that stalls issue on RAW hazards.

---
 rtl/reg_operand_fetch.sv | 113 +++++++++++
 tb/tb_reg_operand_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_operand_fetch.sv
// Operand fetch stage in front of the MIPS register file: reads both sources,
// bypasses same-cycle writeback data and stalls on RAW hazards via per-register pending counters.
module reg_operand_fetch #(
   parameter int PEND_W = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic        in_wen,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_sdata,
   output logic [31:0] out_tdata,
   output logic [4:0]  out_rd,
   output logic        out_wen,
   input  logic        wb_valid,
   input  logic [4:0]  wb_reg,
   input  logic [31:0] wb_data,
   output logic        rf_write,
   output logic [4:0]  rf_wreg,
   output logic [31:0] rf_wdata,
   output logic [4:0]  rf_sreg,
   output logic [4:0]  rf_treg,
   input  logic [31:0] rf_sdata,
   input  logic [31:0] rf_tdata,
   output logic        sb_err
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

   logic [PEND_W-1:0] pend [32];
   logic [31:1]       inc_vec;
   logic [31:1]       dec_vec;
   logic              rs_wb_hit, rt_wb_hit, rd_wb_hit;
   logic              rs_busy, rt_busy, sat, accept;
   logic [31:0]       s_op, t_op;

   assign rf_sreg  = in_rs;
   assign rf_treg  = in_rt;
   assign rf_write = wb_valid && (wb_reg != 5'd0);
   assign rf_wreg  = wb_reg;
   assign rf_wdata = wb_data;

   assign rs_wb_hit = wb_valid && (wb_reg == in_rs);
   assign rt_wb_hit = wb_valid && (wb_reg == in_rt);
   assign rd_wb_hit = wb_valid && (wb_reg == in_rd);

   // The file only commits at the end of the wb cycle, so same-cycle data must be bypassed.
   assign s_op = (in_rs == 5'd0) ? 32'd0 : (rs_wb_hit ? wb_data : rf_sdata);
   assign t_op = (in_rt == 5'd0) ? 32'd0 : (rt_wb_hit ? wb_data : rf_tdata);

   assign rs_busy = (in_rs != 5'd0) && (pend[in_rs] != '0) &&
                    !(rs_wb_hit && (pend[in_rs] == PEND_ONE));
   assign rt_busy = (in_rt != 5'd0) && (pend[in_rt] != '0) &&
                    !(rt_wb_hit && (pend[in_rt] == PEND_ONE));
   assign sat     = in_wen && (in_rd != 5'd0) && (pend[in_rd] == PEND_MAX) && !rd_wb_hit;

   assign in_ready = (!out_valid || out_ready) && !rs_busy && !rt_busy && !sat;
   assign accept   = in_valid && in_ready;

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int r = 1; r < 32; r++) begin
         inc_vec[r] = accept && in_wen && (in_rd == 5'(r));
         dec_vec[r] = wb_valid && (wb_reg == 5'(r)) && (pend[r] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 32; r++) pend[r] <= '0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            if (inc_vec[r] && !dec_vec[r])
               pend[r] <= pend[r] + PEND_ONE;
            else if (dec_vec[r] && !inc_vec[r])
               pend[r] <= pend[r] - PEND_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sb_err <= 1'b0;
      else if (wb_valid && (wb_reg != 5'd0) && (pend[wb_reg] == '0))
         sb_err <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sdata <= '0;
         out_tdata <= '0;
         out_rd    <= '0;
         out_wen   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_sdata <= s_op;
         out_tdata <= t_op;
         out_rd    <= in_rd;
         out_wen   <= in_wen;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Directed bench for reg_operand_fetch, with a small behavioural register file
// hooked to the rf_* ports.
module tb_reg_operand_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid, in_ready, in_wen, out_valid, out_ready, out_wen;
   logic [4:0]  in_rs, in_rt, in_rd, out_rd, wb_reg, rf_wreg, rf_sreg, rf_treg;
   logic [31:0] out_sdata, out_tdata, wb_data, rf_wdata, rf_sdata, rf_tdata;
   logic        wb_valid, rf_write, sb_err;
   logic [31:0] rf_mem [32] = '{default: 32'h0};
   int          n_cmp = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (rf_write) rf_mem[rf_wreg] <= rf_wdata;
   assign rf_sdata = rf_mem[rf_sreg];
   assign rf_tdata = rf_mem[rf_treg];

   reg_operand_fetch #(.PEND_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs), .in_rt(in_rt),
      .in_rd(in_rd), .in_wen(in_wen),
      .out_valid(out_valid), .out_ready(out_ready), .out_sdata(out_sdata),
      .out_tdata(out_tdata), .out_rd(out_rd), .out_wen(out_wen),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
      .rf_write(rf_write), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
      .rf_sreg(rf_sreg), .rf_treg(rf_treg), .rf_sdata(rf_sdata), .rf_tdata(rf_tdata),
      .sb_err(sb_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0; in_wen = 1'b0;
      out_ready = 1'b1; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
   endtask

   task automatic test_reset();
      drive_idle();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: actual %0h required 0", out_valid); end
      n_cmp++; if (out_sdata !== 32'h0 || out_tdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_data: actual %h/%h required 0/0", out_sdata, out_tdata); end
      n_cmp++; if (out_rd !== 5'd0 || out_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_wen: actual %0d/%0h required 0/0", out_rd, out_wen); end
      n_cmp++; if (sb_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sb_err: actual %0h required 0", sb_err); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: actual %0h required 1", in_ready); end
      @(negedge clk) rst_n = 1'b1;
   endtask

   // Seeds r3/r4 through the write port; with nothing pending this also trips sb_err.
   task automatic test_preload();
      tick();
      wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h11;
      #1;
      n_cmp++; if (rf_write !== 1'b1 || rf_wreg !== 5'd3 || rf_wdata !== 32'h11) begin n_fail++; $display("[TB] FAIL preload_rf_write: actual %0h/%0d/%h required 1/3/11", rf_write, rf_wreg, rf_wdata); end
      tick();
      wb_reg = 5'd4; wb_data = 32'h22;
      tick();
      wb_valid = 1'b0;
      n_cmp++; if (sb_err !== 1'b1) begin n_fail++; $display("[TB] FAIL preload_sb_err: actual %0h required 1", sb_err); end
   endtask

   task automatic test_basic_back_to_back();
      tick();
      in_valid = 1'b1; in_rs = 5'd3; in_rt = 5'd4;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_in_ready: actual %0h required 1", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_sdata !== 32'h11 || out_tdata !== 32'h22) begin n_fail++; $display("[TB] FAIL basic_bundle: actual %0h/%h/%h required 1/11/22", out_valid, out_sdata, out_tdata); end
      in_rs = 5'd4; in_rt = 5'd3;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_in_ready: actual %0h required 1", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_sdata !== 32'h22 || out_tdata !== 32'h11) begin n_fail++; $display("[TB] FAIL b2b_bundle: actual %0h/%h/%h required 1/22/11", out_valid, out_sdata, out_tdata); end
      in_valid = 1'b0;
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_drain: actual %0h required 0", out_valid); end
      drive_idle();
   endtask

   task automatic test_bypass();
      tick();
      in_valid = 1'b1; in_wen = 1'b1; in_rd = 5'd5;
      tick();
      n_cmp++; if (out_rd !== 5'd5 || out_wen !== 1'b1) begin n_fail++; $display("[TB] FAIL bypass_writer: actual %0d/%0h required 5/1", out_rd, out_wen); end
      in_wen = 1'b0; in_rd = 5'd0; in_rs = 5'd5;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bypass_stall: actual %0h required 0", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bypass_stall2: actual %0h/%0h required 0/0", out_valid, in_ready); end
      wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'hABCD;
      #1;
      n_cmp++; if (in_ready !== 1'b1 || rf_write !== 1'b1 || rf_wreg !== 5'd5) begin n_fail++; $display("[TB] FAIL bypass_release: actual %0h/%0h/%0d required 1/1/5", in_ready, rf_write, rf_wreg); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_sdata !== 32'hABCD) begin n_fail++; $display("[TB] FAIL bypass_data: actual %0h/%h required 1/abcd", out_valid, out_sdata); end
      drive_idle();
   endtask

   task automatic test_pend_two();
      tick();
      in_valid = 1'b1; in_wen = 1'b1; in_rd = 5'd7;
      tick();
      tick();
      in_wen = 1'b0; in_rd = 5'd0; in_rs = 5'd7;
      wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'h70;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL pend2_first_wb: actual %0h required 0", in_ready); end
      tick();
      wb_data = 32'h77;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL pend2_second_wb: actual %0h required 1", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_sdata !== 32'h77) begin n_fail++; $display("[TB] FAIL pend2_data: actual %0h/%h required 1/77", out_valid, out_sdata); end
      drive_idle();
   endtask

   task automatic test_saturation();
      tick();
      in_valid = 1'b1; in_wen = 1'b1; in_rd = 5'd9;
      tick();
      tick();
      tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_fourth: actual %0h required 0", in_ready); end
      tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_fourth_hold: actual %0h required 0", in_ready); end
      wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h99;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_wb_release: actual %0h required 1", in_ready); end
      tick();
      wb_valid = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_still_three: actual %0h required 0", in_ready); end
      drive_idle();
   endtask

   task automatic test_hold();
      tick();
      in_valid = 1'b1; in_rs = 5'd3; in_rt = 5'd4; out_ready = 1'b0;
      tick();
      in_rs = 5'd4; in_rt = 5'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (out_valid !== 1'b1 || out_sdata !== 32'h11 || out_tdata !== 32'h22 || in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_cycle%0d: actual %0h/%h/%h/%0h required 1/11/22/0", i, out_valid, out_sdata, out_tdata, in_ready); end
      end
      out_ready = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_sdata !== 32'h22) begin n_fail++; $display("[TB] FAIL hold_release: actual %0h/%h required 1/22", out_valid, out_sdata); end
      drive_idle();
   endtask

   task automatic test_zero_reg();
      tick();
      in_valid = 1'b1; in_wen = 1'b1; in_rd = 5'd0;
      wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'hDEAD;
      #1;
      n_cmp++; if (in_ready !== 1'b1 || rf_write !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_ready_write: actual %0h/%0h required 1/0", in_ready, rf_write); end
      tick();
      n_cmp++; if (out_sdata !== 32'h0 || out_tdata !== 32'h0 || sb_err !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_data: actual %h/%h/%0h required 0/0/0", out_sdata, out_tdata, sb_err); end
      drive_idle();
   endtask

   task automatic test_spurious_wb();
      tick();
      wb_valid = 1'b1; wb_reg = 5'd12; wb_data = 32'h1212;
      #1;
      n_cmp++; if (rf_write !== 1'b1) begin n_fail++; $display("[TB] FAIL spur_rf_write: actual %0h required 1", rf_write); end
      tick();
      wb_valid = 1'b0;
      n_cmp++; if (sb_err !== 1'b1) begin n_fail++; $display("[TB] FAIL spur_sb_err: actual %0h required 1", sb_err); end
      tick();
      tick();
      n_cmp++; if (sb_err !== 1'b1) begin n_fail++; $display("[TB] FAIL spur_sticky: actual %0h required 1", sb_err); end
      drive_idle();
   endtask

   task automatic test_async_reset_stall();
      tick();
      in_valid = 1'b1; in_wen = 1'b1; in_rd = 5'd20;
      tick();
      in_wen = 1'b0; in_rd = 5'd0; in_rs = 5'd20;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_stall: actual %0h required 0", in_ready); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || sb_err !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL arst_clear: actual %0h/%0h/%0h required 0/0/1", out_valid, sb_err, in_ready); end
      @(negedge clk) rst_n = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_sdata !== 32'h0) begin n_fail++; $display("[TB] FAIL arst_after: actual %0h/%h required 1/0", out_valid, out_sdata); end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_preload();
      test_reset();
      test_basic_back_to_back();
      test_bypass();
      test_pend_two();
      test_saturation();
      test_hold();
      test_zero_reg();
      test_spurious_wb();
      test_async_reset_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
